// File: rtl/ep_alu_bank.sv
// ep_alu_bank: multi-channel arithmetic engine behind host wire/trigger endpoints.
// NUM_CH independent channels, each WIDTH bits wide, with ADD/SUB/AND/XOR,
// a running accumulator, an iterative shift-add multiplier, busy/done
// handshakes and sticky status flags.
//
// Ports (all synchronous to ti_clk, rising edge):
//   ti_clk      host-interface clock
//   ti_rst_n    synchronous active-low reset
//   a_in, b_in  operands, channel c at [c*WIDTH +: WIDTH]
//   op_in       opcodes, channel c at [c*3 +: 3]
//   start       one-cycle start pulse per channel
//   status_clr  one-cycle pulse clearing a channel's sticky flags
//   result      registered result per channel
//   busy        channel executing
//   done        one-cycle completion pulse
//   ovf/ovr/err sticky overflow, start-while-busy, illegal opcode
//
// Build option: define EP_ALU_SATURATE_EN to clamp ADD/ACC/MUL to all-ones on
// overflow and SUB to zero on borrow (ovf still set, latency unchanged).
module ep_alu_bank #(
    parameter int NUM_CH = 4,
    parameter int WIDTH  = 16
) (
    input  logic                    ti_clk,
    input  logic                    ti_rst_n,
    input  logic [NUM_CH*WIDTH-1:0] a_in,
    input  logic [NUM_CH*WIDTH-1:0] b_in,
    input  logic [NUM_CH*3-1:0]     op_in,
    input  logic [NUM_CH-1:0]       start,
    input  logic [NUM_CH-1:0]       status_clr,
    output logic [NUM_CH*WIDTH-1:0] result,
    output logic [NUM_CH-1:0]       busy,
    output logic [NUM_CH-1:0]       done,
    output logic [NUM_CH-1:0]       ovf,
    output logic [NUM_CH-1:0]       ovr,
    output logic [NUM_CH-1:0]       err
);

`ifdef EP_ALU_SATURATE_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MUL} state_t;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            state_t             state_q, state_d;
            logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, acc_q, acc_d, res_q, res_d;
            logic [2:0]         op_q, op_d;
            logic [2*WIDTH-1:0] prod_q, prod_d, mcand_q, mcand_d;
            logic [CNT_W-1:0]   cnt_q, cnt_d;
            logic               busy_q, busy_d, done_q, done_d;
            logic               ovf_q, ovf_d, ovr_q, ovr_d, err_q, err_d;
            logic               set_ovf, set_ovr, set_err, op_clr_ovf;
            logic [WIDTH:0]     sum_w, diff_w, acc_sum_w;

            always_comb begin
                state_d    = state_q;
                a_d        = a_q;
                b_d        = b_q;
                op_d       = op_q;
                acc_d      = acc_q;
                res_d      = res_q;
                prod_d     = prod_q;
                mcand_d    = mcand_q;
                cnt_d      = cnt_q;
                busy_d     = busy_q;
                done_d     = 1'b0;
                set_ovf    = 1'b0;
                set_ovr    = 1'b0;
                set_err    = 1'b0;
                op_clr_ovf = 1'b0;
                sum_w      = {1'b0, a_q} + {1'b0, b_q};
                diff_w     = {1'b0, a_q} - {1'b0, b_q};
                acc_sum_w  = {1'b0, acc_q} + {1'b0, a_q};

                case (state_q)
                    S_IDLE: begin
                        if (start[gi]) begin
                            a_d     = a_in[gi*WIDTH +: WIDTH];
                            b_d     = b_in[gi*WIDTH +: WIDTH];
                            op_d    = op_in[gi*3 +: 3];
                            prod_d  = '0;
                            mcand_d = {{WIDTH{1'b0}}, a_in[gi*WIDTH +: WIDTH]};
                            cnt_d   = '0;
                            busy_d  = 1'b1;
                            state_d = (op_in[gi*3 +: 3] == 3'd5) ? S_MUL : S_EXEC;
                        end
                    end
                    S_EXEC: begin
                        // A start on the completing edge still counts as busy.
                        set_ovr = start[gi];
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        case (op_q)
                            3'd0: begin
                                set_ovf = sum_w[WIDTH];
                                res_d   = (SAT_EN && sum_w[WIDTH]) ? '1 : sum_w[WIDTH-1:0];
                            end
                            3'd1: begin
                                // Top bit of the extended difference is the borrow.
                                set_ovf = diff_w[WIDTH];
                                res_d   = (SAT_EN && diff_w[WIDTH]) ? '0 : diff_w[WIDTH-1:0];
                            end
                            3'd2: res_d = a_q & b_q;
                            3'd3: res_d = a_q ^ b_q;
                            3'd4: begin
                                set_ovf = acc_sum_w[WIDTH];
                                acc_d   = (SAT_EN && acc_sum_w[WIDTH]) ? '1 : acc_sum_w[WIDTH-1:0];
                                res_d   = acc_d;
                            end
                            3'd6: begin
                                acc_d      = '0;
                                res_d      = '0;
                                op_clr_ovf = 1'b1;
                            end
                            default: set_err = 1'b1;
                        endcase
                    end
                    S_MUL: begin
                        set_ovr = start[gi];
                        if (cnt_q == CNT_W'(WIDTH)) begin
                            state_d = S_IDLE;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                            set_ovf = |prod_q[2*WIDTH-1:WIDTH];
                            res_d   = (SAT_EN && (|prod_q[2*WIDTH-1:WIDTH])) ? '1 : prod_q[WIDTH-1:0];
                        end else begin
                            // One multiplier bit per cycle regardless of value,
                            // so latency never depends on the data.
                            if (b_q[0]) begin
                                prod_d = prod_q + mcand_q;
                            end
                            mcand_d = mcand_q << 1;
                            b_d     = b_q >> 1;
                            cnt_d   = cnt_q + CNT_W'(1);
                        end
                    end
                    default: begin
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                    end
                endcase

                // Clear first, then set, so a coincident set wins.
                ovf_d = status_clr[gi] ? 1'b0 : ovf_q;
                ovr_d = status_clr[gi] ? 1'b0 : ovr_q;
                err_d = status_clr[gi] ? 1'b0 : err_q;
                if (op_clr_ovf) ovf_d = 1'b0;
                if (set_ovf)    ovf_d = 1'b1;
                if (set_ovr)    ovr_d = 1'b1;
                if (set_err)    err_d = 1'b1;
            end

            always_ff @(posedge ti_clk) begin
                if (!ti_rst_n) begin
                    state_q <= S_IDLE;
                    a_q     <= '0;
                    b_q     <= '0;
                    op_q    <= '0;
                    acc_q   <= '0;
                    res_q   <= '0;
                    prod_q  <= '0;
                    mcand_q <= '0;
                    cnt_q   <= '0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    ovf_q   <= 1'b0;
                    ovr_q   <= 1'b0;
                    err_q   <= 1'b0;
                end else begin
                    state_q <= state_d;
                    a_q     <= a_d;
                    b_q     <= b_d;
                    op_q    <= op_d;
                    acc_q   <= acc_d;
                    res_q   <= res_d;
                    prod_q  <= prod_d;
                    mcand_q <= mcand_d;
                    cnt_q   <= cnt_d;
                    busy_q  <= busy_d;
                    done_q  <= done_d;
                    ovf_q   <= ovf_d;
                    ovr_q   <= ovr_d;
                    err_q   <= err_d;
                end
            end

            assign result[gi*WIDTH +: WIDTH] = res_q;
            assign busy[gi] = busy_q;
            assign done[gi] = done_q;
            assign ovf[gi]  = ovf_q;
            assign ovr[gi]  = ovr_q;
            assign err[gi]  = err_q;
        end
    endgenerate

endmodule

// File: tb/tb_ep_alu_bank.sv
// Testbench for ep_alu_bank: directed scenarios with literal expectations plus
// a randomized phase, all cross-checked every cycle against a behavioural
// model that computes each operation's final value with plain arithmetic.
module tb_ep_alu_bank;
    localparam int NUM_CH = 4;
    localparam int WIDTH  = 16;
    localparam longint MASK = (64'd1 << WIDTH) - 1;
`ifdef EP_ALU_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic                    ti_clk = 1'b0;
    logic                    ti_rst_n = 1'b0;
    logic [NUM_CH*WIDTH-1:0] a_in = '0;
    logic [NUM_CH*WIDTH-1:0] b_in = '0;
    logic [NUM_CH*3-1:0]     op_in = '0;
    logic [NUM_CH-1:0]       start = '0;
    logic [NUM_CH-1:0]       status_clr = '0;
    logic [NUM_CH*WIDTH-1:0] result;
    logic [NUM_CH-1:0]       busy, done, ovf, ovr, err;

    ep_alu_bank #(.NUM_CH(NUM_CH), .WIDTH(WIDTH)) dut (
        .ti_clk(ti_clk), .ti_rst_n(ti_rst_n), .a_in(a_in), .b_in(b_in),
        .op_in(op_in), .start(start), .status_clr(status_clr),
        .result(result), .busy(busy), .done(done), .ovf(ovf), .ovr(ovr), .err(err)
    );

    always #5 ti_clk = ~ti_clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    longint m_a[NUM_CH], m_b[NUM_CH], m_acc[NUM_CH], m_res[NUM_CH];
    int     m_op[NUM_CH], m_rem[NUM_CH];
    bit     m_done[NUM_CH], m_ovf[NUM_CH], m_ovr[NUM_CH], m_err[NUM_CH];
    bit     started = 1'b0;

    always @(posedge ti_clk) begin
        bit s_ovf, s_ovr, s_err, c_ovf;
        longint t;
        started = 1'b1;
        for (int c = 0; c < NUM_CH; c++) begin
            if (!ti_rst_n) begin
                m_a[c] = 0; m_b[c] = 0; m_acc[c] = 0; m_res[c] = 0;
                m_op[c] = 0; m_rem[c] = 0;
                m_done[c] = 0; m_ovf[c] = 0; m_ovr[c] = 0; m_err[c] = 0;
            end else begin
                s_ovf = 0; s_ovr = 0; s_err = 0; c_ovf = 0;
                m_done[c] = 0;
                if (m_rem[c] > 0) begin
                    if (start[c]) s_ovr = 1;
                    m_rem[c]--;
                    if (m_rem[c] == 0) begin
                        m_done[c] = 1;
                        case (m_op[c])
                            0: begin
                                t = m_a[c] + m_b[c];
                                s_ovf = (t > MASK);
                                m_res[c] = (s_ovf && SAT) ? MASK : (t & MASK);
                            end
                            1: begin
                                s_ovf = (m_a[c] < m_b[c]);
                                m_res[c] = (s_ovf && SAT) ? 0 : ((m_a[c] - m_b[c]) & MASK);
                            end
                            2: m_res[c] = m_a[c] & m_b[c];
                            3: m_res[c] = m_a[c] ^ m_b[c];
                            4: begin
                                t = m_acc[c] + m_a[c];
                                s_ovf = (t > MASK);
                                m_acc[c] = (s_ovf && SAT) ? MASK : (t & MASK);
                                m_res[c] = m_acc[c];
                            end
                            5: begin
                                t = m_a[c] * m_b[c];
                                s_ovf = (t > MASK);
                                m_res[c] = (s_ovf && SAT) ? MASK : (t & MASK);
                            end
                            6: begin
                                m_acc[c] = 0; m_res[c] = 0; c_ovf = 1;
                            end
                            default: s_err = 1;
                        endcase
                    end
                end else if (start[c]) begin
                    m_a[c]  = longint'(a_in[c*WIDTH +: WIDTH]);
                    m_b[c]  = longint'(b_in[c*WIDTH +: WIDTH]);
                    m_op[c] = int'(op_in[c*3 +: 3]);
                    m_rem[c] = (m_op[c] == 5) ? WIDTH + 1 : 1;
                end
                if (status_clr[c]) begin
                    m_ovf[c] = 0; m_ovr[c] = 0; m_err[c] = 0;
                end
                if (c_ovf) m_ovf[c] = 0;
                if (s_ovf) m_ovf[c] = 1;
                if (s_ovr) m_ovr[c] = 1;
                if (s_err) m_err[c] = 1;
            end
        end
    end

    // Compare process: every cycle, on the falling edge.
    always @(negedge ti_clk) begin
        logic [NUM_CH*WIDTH-1:0] e_res;
        logic [NUM_CH-1:0] e_busy, e_done, e_ovf, e_ovr, e_err;
        if (started) begin
            for (int c = 0; c < NUM_CH; c++) begin
                e_res[c*WIDTH +: WIDTH] = m_res[c][WIDTH-1:0];
                e_busy[c] = (m_rem[c] > 0);
                e_done[c] = m_done[c];
                e_ovf[c]  = m_ovf[c];
                e_ovr[c]  = m_ovr[c];
                e_err[c]  = m_err[c];
            end
            chk("model_result", result, e_res);
            chk("model_busy", busy, e_busy);
            chk("model_done", done, e_done);
            chk("model_ovf", ovf, e_ovf);
            chk("model_ovr", ovr, e_ovr);
            chk("model_err", err, e_err);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic pulse(input int c, input logic [2:0] op,
                         input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        a_in[c*WIDTH +: WIDTH] = a;
        b_in[c*WIDTH +: WIDTH] = b;
        op_in[c*3 +: 3] = op;
        start[c] = 1'b1;
        @(negedge ti_clk);
        start[c] = 1'b0;
    endtask

    task automatic wait_done(input int c);
        int n = 0;
        while (!done[c] && n < 200) begin
            @(negedge ti_clk);
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL wait_done ch%0d: done never seen within 200 cycles", c);
        end
    endtask

    function automatic logic [WIDTH-1:0] res_of(input int c);
        return result[c*WIDTH +: WIDTH];
    endfunction

    initial begin
        int n;
        logic [WIDTH-1:0] vals[5];
        logic [WIDTH-1:0] exps[5];
        logic [2:0] ops[5];

        repeat (3) @(negedge ti_clk);
        chk("reset_result", result, 0);
        chk("reset_busy", busy, 0);
        chk("reset_flags", {done, ovf, ovr, err}, 0);
        ti_rst_n = 1'b1;
        @(negedge ti_clk);

        // ADD with carry
        pulse(0, 3'd0, 16'hFFFF, 16'h0002);
        chk("add_busy", busy[0], 1);
        chk("add_done_early", done[0], 0);
        @(negedge ti_clk);
        chk("add_done", done[0], 1);
        chk("add_result", res_of(0), SAT ? 16'hFFFF : 16'h0001);
        chk("add_ovf", ovf[0], 1);
        chk("add_busy_clear", busy[0], 0);
        @(negedge ti_clk);
        chk("add_done_one_cycle", done[0], 0);

        // MUL latency and results
        pulse(1, 3'd5, 16'h0123, 16'h0010);
        n = 0;
        while (busy[1] && n < 100) begin
            n++;
            @(negedge ti_clk);
        end
        chk("mul_busy_len", n, 17);
        chk("mul_done", done[1], 1);
        chk("mul_result", res_of(1), 16'h1230);
        chk("mul_ovf0", ovf[1], 0);
        @(negedge ti_clk);
        pulse(1, 3'd5, 16'h1000, 16'h0010);
        wait_done(1);
        chk("mul_ovf_result", res_of(1), SAT ? 16'hFFFF : 16'h0000);
        chk("mul_ovf1", ovf[1], 1);
        @(negedge ti_clk);

        // Accumulator sequence
        vals = '{16'd5, 16'd7, 16'd9, 16'd0, 16'd1};
        ops  = '{3'd4, 3'd4, 3'd4, 3'd6, 3'd4};
        exps = '{16'd5, 16'd12, 16'd21, 16'd0, 16'd1};
        for (int i = 0; i < 5; i++) begin
            pulse(2, ops[i], vals[i], 16'd0);
            @(negedge ti_clk);
            chk("acc_seq", res_of(2), exps[i]);
        end

        // Overrun during MUL
        status_clr[1] = 1'b1;
        @(negedge ti_clk);
        status_clr[1] = 1'b0;
        chk("ovf_cleared", ovf[1], 0);
        pulse(1, 3'd5, 16'd2, 16'd3);
        @(negedge ti_clk);
        @(negedge ti_clk);
        pulse(1, 3'd5, 16'h0077, 16'd3);
        chk("ovr_set", ovr[1], 1);
        chk("ovr_result_held", res_of(1), SAT ? 16'hFFFF : 16'h0000);
        wait_done(1);
        chk("ovr_first_mul_kept", res_of(1), 16'd6);
        @(negedge ti_clk);
        status_clr[1] = 1'b1;
        @(negedge ti_clk);
        status_clr[1] = 1'b0;
        chk("ovr_cleared", ovr[1], 0);
        pulse(1, 3'd5, 16'd2, 16'd3);
        start[1] = 1'b1;
        status_clr[1] = 1'b1;
        @(negedge ti_clk);
        start[1] = 1'b0;
        status_clr[1] = 1'b0;
        chk("ovr_set_wins", ovr[1], 1);
        wait_done(1);
        @(negedge ti_clk);

        // Illegal opcode
        pulse(3, 3'd0, 16'd10, 16'd20);
        @(negedge ti_clk);
        chk("ch3_add", res_of(3), 16'd30);
        pulse(3, 3'd7, 16'd1, 16'd1);
        @(negedge ti_clk);
        chk("illegal_done", done[3], 1);
        chk("illegal_err", err[3], 1);
        chk("illegal_result_held", res_of(3), 16'd30);
        @(negedge ti_clk);

        // All channels concurrently
        a_in  = {16'hA5A5, 16'd7, 16'd5, 16'd100};
        b_in  = {16'h0F0F, 16'd9, 16'd9, 16'd23};
        op_in = {3'd3, 3'd5, 3'd1, 3'd0};
        start = 4'hF;
        @(negedge ti_clk);
        start = 4'h0;
        wait_done(2);
        chk("conc_add", res_of(0), 16'd123);
        chk("conc_sub", res_of(1), SAT ? 16'h0000 : 16'hFFFC);
        chk("conc_mul", res_of(2), 16'd63);
        chk("conc_xor", res_of(3), 16'hAAAA);
        @(negedge ti_clk);

        // Reset during MUL
        pulse(1, 3'd5, 16'h00FF, 16'h00FF);
        repeat (3) @(negedge ti_clk);
        ti_rst_n = 1'b0;
        @(negedge ti_clk);
        chk("midrst_result", result, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_flags", {done, ovf, ovr, err}, 0);
        ti_rst_n = 1'b1;
        @(negedge ti_clk);
        chk("post_rst_no_done", done, 0);
        pulse(0, 3'd0, 16'd3, 16'd4);
        @(negedge ti_clk);
        chk("post_rst_add", res_of(0), 16'd7);
        chk("post_rst_done", done[0], 1);

        // Randomized phase
        for (int i = 0; i < 4000; i++) begin
            @(negedge ti_clk);
            a_in  = {$urandom, $urandom};
            b_in  = {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) b_in[15:0] = 16'hFFFF;
            op_in = 12'($urandom);
            for (int c = 0; c < NUM_CH; c++) begin
                start[c]      = ($urandom_range(0, 5) == 0);
                status_clr[c] = ($urandom_range(0, 15) == 0);
            end
            ti_rst_n = ($urandom_range(0, 599) != 0);
        end
        @(negedge ti_clk);
        start = '0;
        status_clr = '0;
        ti_rst_n = 1'b1;
        repeat (40) @(negedge ti_clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ep_alu_bank.md
Name: ep_alu_bank

Overview:
- Multi-channel arithmetic engine placed behind the host wire/trigger endpoints.
- Generalises the fixed single 16-bit adder to NUM_CH independent channels of WIDTH bits.
- Each channel supports selectable operations, a running accumulator and an iterative multiplier, with busy/done handshakes and sticky status.
- Operands, opcodes and start pulses come from wire-ins and trigger-ins; results and status go to wire-outs and trigger-outs in the host-interface clock domain.

Parameters:
- NUM_CH, 4, number of independent channels (1..8)
- WIDTH, 16, operand/result width in bits (2..32)

Ports:
- ti_clk  input  1  host-interface clock; all logic rising-edge
- ti_rst_n  input  1  synchronous active-low reset
- a_in  input  NUM_CH*WIDTH  operand A; channel c at [c*WIDTH +: WIDTH]
- b_in  input  NUM_CH*WIDTH  operand B, same packing
- op_in  input  NUM_CH*3  opcode; channel c at [c*3 +: 3]
- start  input  NUM_CH  one-cycle start pulse per channel (trigger-in)
- status_clr  input  NUM_CH  one-cycle pulse; clears that channel's sticky flags
- result  output  NUM_CH*WIDTH  registered result per channel
- busy  output  NUM_CH  channel executing
- done  output  NUM_CH  one-cycle completion pulse (trigger-out)
- ovf  output  NUM_CH  sticky overflow/carry/borrow
- ovr  output  NUM_CH  sticky start-while-busy
- err  output  NUM_CH  sticky illegal opcode

Behaviour:
- Reset (ti_rst_n=0 at an edge): all outputs 0, every FSM to IDLE, accumulators 0.
  - Applies mid-operation; no done pulse for an aborted operation.
- Per-channel FSM: IDLE, EXEC, MUL. All channels are fully independent.
- IDLE + start=1 at edge k:
  - Capture A, B and op into internal registers; later input changes are ignored.
  - op 5 -> MUL; all other ops -> EXEC. busy=1 from edge k.
- EXEC: at edge k+1, write result, update flags, done=1 for exactly one cycle, busy=0, return to IDLE. Latency 2 edges start-to-done.
- Opcodes (arithmetic is modulo 2^WIDTH):
  - 0 ADD: A+B; ovf set on carry out.
  - 1 SUB: A-B; ovf set on borrow (A<B unsigned).
  - 2 AND: A&B.
  - 3 XOR: A^B.
  - 4 ACC: acc<=acc+A; result=new acc; ovf on carry.
  - 5 MUL: unsigned shift-add, LSB of B first, one bit per cycle.
    - Result is the low WIDTH bits; ovf set if the upper WIDTH bits are non-zero.
    - done at edge k+WIDTH+1.
  - 6 CLR: acc<=0, result<=0, ovf<=0; done pulses normally.
  - 7: illegal; result unchanged, err<=1, done pulses normally.
- result holds its value until the next write; no other op modifies acc.
- start while busy=1: ignored (captured operands untouched), ovr<=1.
- start on the same edge that done is asserted:
  - FSM is leaving EXEC/MUL at that edge, so the start is still "while busy": ignored, ovr<=1.
- Sticky flags: status_clr clears ovf/ovr/err.
  - If a set and a clear occur on the same edge, set wins.
- MUL boundaries:
  - WIDTH=2 is legal.
  - B=0 still takes the full WIDTH cycles; latency is constant and never data-dependent.

Optional Feature:
- Macro: EP_ALU_SATURATE_EN.
- Defined:
  - ADD, ACC and MUL clamp to 2^WIDTH-1 on overflow.
  - SUB clamps to 0 on borrow.
  - ovf is still set in all of these cases.
- Undefined: wrap-around as specified above. Latency is identical in both builds.

Test Plan:
- Reset then ch0 op0 A=16'hFFFF B=16'h0002 start -> result0=16'h0001, ovf0=1, done0 pulse 2 edges after start; with EP_ALU_SATURATE_EN, result0=16'hFFFF.
- ch1 op5 A=16'h0123 B=16'h0010 -> busy1 for 17 edges, result1=16'h1230, ovf1=0. Same op with A=16'h1000 B=16'h0010 -> result1=16'h0000, ovf1=1.
- ch2 ACC with A=5, 7, 9 in sequence, then op6, then ACC A=1 -> result2 reads 5, 12, 21, 0, 1.
- ch1 MUL started; second start at edge+3 with new A -> ovr1=1, result unchanged from first MUL. Then status_clr1 -> ovr1=0; a status_clr1 coincident with a new overrun -> ovr1 stays 1.
- Illegal op7 on ch3 -> err3=1, result3 unchanged, done3 pulses. Run all 4 channels concurrently (ADD, SUB, MUL, XOR) -> results independent and correct.
- ti_rst_n=0 at the 5th cycle of a MUL -> all outputs 0 next edge, no done pulse; a subsequent ADD 3+4 -> 7.
